plab4_net_router_input_queue: RTL and testbench
===============================================

PLAB4_NET_ROUTER_INPUT_QUEUE -- requirements
Module: plab4_net_router_input_queue

Interface
REQ-001 SHALL have parameter p_router_id, default 0, this router's ring index.
REQ-002 SHALL have parameter p_num_routers, default 8, ring size, power of two; c_dest_nbits = $clog2(p_num_routers).
REQ-003 SHALL have parameter p_msg_nbits, default 32, message width; dest field = msg[p_msg_nbits-1 -: c_dest_nbits].
REQ-004 SHALL have parameter p_num_entries, default 4, queue depth, power of two, at least 2.
REQ-005 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-006 SHALL have port reset, input, 1; one clock; reset is asynchronous and active-low.
REQ-007 SHALL have port domain, input, 1, security domain label of all traffic; quasi-static.
REQ-008 SHALL have port in_val, input, 1, upstream message valid.
REQ-009 SHALL have port in_rdy, output, 1, queue can accept.
REQ-010 SHALL have port in_msg, input, p_msg_nbits, incoming message.
REQ-011 SHALL have port out_val, output, 3, one-hot request; bit0 PREV, bit1 NEXT, bit2 TERM.
REQ-012 SHALL have port out_rdy, input, 3, per-output grant/ready, same bit order.
REQ-013 SHALL have port out_msg, output, p_msg_nbits, head message, shared by all outputs.
REQ-014 SHALL have port count, output, $clog2(p_num_entries)+1, current occupancy.

Function
REQ-015 SHALL be a circular FIFO: write pointer, read pointer, occupancy counter; pointers wrap modulo p_num_entries.
REQ-016 SHALL enqueue in_msg on the clock edge where in_val && in_rdy.
REQ-017 SHALL drive in_rdy = (count != p_num_entries); no combinational dependence on out_rdy.
REQ-018 SHALL compute head route with plab4_net_GreedyRouteCompute (p_router_id, p_num_routers, domain) on head dest.
REQ-019 Route rule: dest == p_router_id -> TERM; else (dest - id) mod N < (id - dest) mod N -> NEXT; else PREV (ties PREV).
REQ-020 SHALL assert exactly the one out_val bit selected by the head route when count > 0; out_val = 3'b000 when empty.
REQ-021 SHALL dequeue the head on the edge where |(out_val & out_rdy); out_rdy bits for unrequested outputs are ignored.
REQ-022 out_val and out_msg SHALL stay stable while a request is pending and unaccepted.
REQ-023 Simultaneous enq and deq: count unchanged, both pointers advance; legal at any non-full occupancy.
REQ-024 Full: in_rdy = 0; enq attempts ignored, no overwrite; deq in same cycle does not raise in_rdy until next cycle.
REQ-025 Empty: no deq; out_msg value don't-care.
REQ-026 Latency: message enqueued at edge k is presented on out_* in cycle k+1 when queue was empty (non-bypass build).

Reset
REQ-027 While reset = 0: pointers = 0, count = 0, in_rdy = 1 (after count clears), out_val = 3'b000; storage not cleared.
REQ-028 Reset asserted mid-transfer SHALL discard all queued messages immediately; no partial deq on deassertion edge.

Configuration
REQ-029 Macro PLAB4_NET_INPUT_QUEUE_BYPASS_EN defined: when count == 0 and in_val, in_msg SHALL route combinationally to out_msg/out_val in the same cycle; if accepted, not written to storage, count stays 0; in_rdy unchanged.
REQ-030 Macro undefined: no bypass path; behaviour exactly per REQ-026, no in_* to out_* combinational path.

Verification (p_router_id=2, p_num_routers=8, p_num_entries=4)
REQ-031 Reset low mid-stream with count=3 -> count=0, out_val=000, in_rdy=1 immediately, no message emitted after release.
REQ-032 Enqueue dest 2, 3, 5, 0, 6 with out_rdy=111 -> out_val sequence 100, 010, 010, 001, 001 (tie at 6 -> PREV), order preserved.
REQ-033 out_rdy=000, 5 enq attempts -> 4 accepted, in_rdy=0, count=4; then out_rdy=111 -> 4 messages in order, count drains to 0.
REQ-034 Head dest 3 (NEXT) with out_rdy=101 for 3 cycles -> no deq, out_val=010 and out_msg held; out_rdy=010 -> deq next edge.
REQ-035 Count=2, enq and deq same edge for 10 cycles -> count stays 2, pointers wrap, data order intact.
REQ-036 Empty queue, in_val with dest 2, out_rdy=100: BYPASS_EN -> out_val=100 same cycle, count stays 0; without macro -> out_val=100 next cycle, count 1 then 0.

Source files
------------

// File: rtl/plab4_net_router_input_queue.sv
// Ring-router input FIFO: circular buffer whose head message requests one of PREV/NEXT/TERM.
// Define PLAB4_NET_INPUT_QUEUE_BYPASS_EN to forward in_msg straight to out_* while the queue is empty.

module plab4_net_GreedyRouteCompute #(
  parameter int p_router_id   = 0,
  parameter int p_num_routers = 8
) (
  input  logic                               domain,
  input  logic [$clog2(p_num_routers)-1:0]   dest,
  output logic [2:0]                         route
);

  localparam int c_dest_nbits = $clog2(p_num_routers);
  localparam logic [c_dest_nbits-1:0] c_id = c_dest_nbits'(p_router_id);

  // Routing is the same for every domain; the label is carried for interface compatibility.
  logic unused_domain;
  assign unused_domain = domain;

  logic [c_dest_nbits-1:0] fwd_hops;
  logic [c_dest_nbits-1:0] bwd_hops;

  assign fwd_hops = dest - c_id;
  assign bwd_hops = c_id - dest;

  always_comb begin
    route = 3'b001;
    if (dest == c_id)
      route = 3'b100;
    else if (fwd_hops < bwd_hops)
      route = 3'b010;
  end

endmodule

module plab4_net_router_input_queue #(
  parameter int p_router_id   = 0,
  parameter int p_num_routers = 8,
  parameter int p_msg_nbits   = 32,
  parameter int p_num_entries = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              domain,
  input  logic                              in_val,
  output logic                              in_rdy,
  input  logic [p_msg_nbits-1:0]            in_msg,
  output logic [2:0]                        out_val,
  input  logic [2:0]                        out_rdy,
  output logic [p_msg_nbits-1:0]            out_msg,
  output logic [$clog2(p_num_entries):0]    count
);

  localparam int c_dest_nbits  = $clog2(p_num_routers);
  localparam int c_ptr_nbits   = $clog2(p_num_entries);
  localparam int c_count_nbits = c_ptr_nbits + 1;

  logic [p_msg_nbits-1:0]   entries [p_num_entries];
  logic [c_ptr_nbits-1:0]   wr_ptr_reg;
  logic [c_ptr_nbits-1:0]   rd_ptr_reg;
  logic [c_count_nbits-1:0] count_reg;

  logic                   empty;
  logic                   bypass;
  logic                   enq;
  logic                   deq;
  logic                   wr_en;
  logic                   rd_en;
  logic [p_msg_nbits-1:0] head_msg;
  logic [2:0]             route;

  assign empty  = (count_reg == '0);
  assign in_rdy = (count_reg != c_count_nbits'(p_num_entries));
  assign enq    = in_val && in_rdy;

`ifdef PLAB4_NET_INPUT_QUEUE_BYPASS_EN
  assign bypass   = empty && in_val;
  assign head_msg = bypass ? in_msg : entries[rd_ptr_reg];
`else
  assign bypass   = 1'b0;
  assign head_msg = entries[rd_ptr_reg];
`endif

  plab4_net_GreedyRouteCompute #(
    .p_router_id   (p_router_id),
    .p_num_routers (p_num_routers)
  ) route_compute (
    .domain (domain),
    .dest   (head_msg[p_msg_nbits-1 -: c_dest_nbits]),
    .route  (route)
  );

  assign out_val = (!empty || bypass) ? route : 3'b000;
  assign out_msg = head_msg;
  assign count   = count_reg;

  // Grants on outputs we are not requesting fall out of the AND with out_val.
  assign deq = |(out_val & out_rdy);

  // A bypassed message that is taken the same cycle never touches storage.
  assign wr_en = enq && !(bypass && deq);
  assign rd_en = deq && !bypass;

  always_ff @(posedge clk) begin
    if (wr_en)
      entries[wr_ptr_reg] <= in_msg;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en)
        wr_ptr_reg <= wr_ptr_reg + c_ptr_nbits'(1);
      if (rd_en)
        rd_ptr_reg <= rd_ptr_reg + c_ptr_nbits'(1);
      count_reg <= count_reg + c_count_nbits'(wr_en) - c_count_nbits'(rd_en);
    end
  end

endmodule

// File: tb/tb_plab4_net_router_input_queue.sv
// Directed bench for plab4_net_router_input_queue (router 2 of 8, depth 4).

module tb_plab4_net_router_input_queue;

  logic        clk;
  logic        reset;
  logic        domain;
  logic        in_val;
  logic        in_rdy;
  logic [31:0] in_msg;
  logic [2:0]  out_val;
  logic [2:0]  out_rdy;
  logic [31:0] out_msg;
  logic [2:0]  count;

  int n_checks;
  int n_fail;

  logic [31:0] sb [$];
  logic [31:0] a_msg [5];
  logic [2:0]  a_route [5];
  logic [31:0] b_msg [5];
  logic [31:0] hold_msg;

  plab4_net_router_input_queue #(
    .p_router_id   (2),
    .p_num_routers (8),
    .p_msg_nbits   (32),
    .p_num_entries (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .domain  (domain),
    .in_val  (in_val),
    .in_rdy  (in_rdy),
    .in_msg  (in_msg),
    .out_val (out_val),
    .out_rdy (out_rdy),
    .out_msg (out_msg),
    .count   (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [2:0] dest, input int tag);
    return {dest, 29'(tag)};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    domain   = 1'b0;
    in_val   = 1'b0;
    in_msg   = '0;
    out_rdy  = 3'b000;

    a_msg   = '{mk(3'd2, 1), mk(3'd3, 2), mk(3'd5, 3), mk(3'd0, 4), mk(3'd6, 5)};
    a_route = '{3'b100, 3'b010, 3'b010, 3'b001, 3'b001};
    b_msg   = '{mk(3'd3, 10), mk(3'd4, 11), mk(3'd0, 12), mk(3'd1, 13), mk(3'd7, 14)};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check_val("rst_count", count, 0);
    check_val("rst_out_val", out_val, 3'b000);
    check_val("rst_in_rdy", in_rdy, 1);
    reset = 1'b1;
    @(negedge clk);

    // Route sequence with everything granted
    out_rdy = 3'b111;
    for (int i = 0; i < 5; i++) begin
      in_val = 1'b1;
      in_msg = a_msg[i];
      #1;
      if (i > 0) begin
        check_val("a_route", out_val, a_route[i-1]);
        check_val("a_msg", out_msg, a_msg[i-1]);
        check_val("a_count", count, 1);
      end
      tick();
    end
    in_val = 1'b0;
    #1;
    check_val("a_route_last", out_val, a_route[4]);
    check_val("a_msg_last", out_msg, a_msg[4]);
    tick();
    check_val("a_drained", count, 0);
    check_val("a_idle_val", out_val, 3'b000);

    // Fill to full with no grants; fifth attempt must be dropped
    out_rdy = 3'b000;
    for (int i = 0; i < 5; i++) begin
      in_val = 1'b1;
      in_msg = b_msg[i];
      #1;
      check_val("b_in_rdy", in_rdy, (i < 4) ? 1 : 0);
      tick();
    end
    check_val("b_full_count", count, 4);
    check_val("b_full_head", out_msg, b_msg[0]);
    // Dequeue while full with a pending enqueue: in_rdy must stay low this cycle
    in_msg  = mk(3'd5, 99);
    out_rdy = 3'b111;
    #1;
    check_val("b_full_deq_rdy", in_rdy, 0);
    tick();
    in_val = 1'b0;
    check_val("b_after_deq_count", count, 3);
    check_val("b_after_deq_rdy", in_rdy, 1);
    for (int i = 1; i < 4; i++) begin
      check_val("b_order", out_msg, b_msg[i]);
      check_val("b_count", count, 32'(4 - i));
      tick();
    end
    check_val("b_drained", count, 0);

    // Head wants NEXT; grants on other outputs must not dequeue
    out_rdy  = 3'b000;
    hold_msg = mk(3'd3, 20);
    in_val   = 1'b1;
    in_msg   = hold_msg;
    tick();
    in_val  = 1'b0;
    out_rdy = 3'b101;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_val("c_hold_val", out_val, 3'b010);
      check_val("c_hold_msg", out_msg, hold_msg);
      tick();
    end
    check_val("c_hold_count", count, 1);
    out_rdy = 3'b010;
    tick();
    check_val("c_deq_count", count, 0);

    // Steady enq+deq at occupancy 2 across pointer wrap
    out_rdy = 3'b000;
    for (int i = 0; i < 2; i++) begin
      in_val = 1'b1;
      in_msg = mk(3'(i), 100 + i);
      sb.push_back(in_msg);
      tick();
    end
    check_val("d_prefill", count, 2);
    out_rdy = 3'b111;
    for (int i = 2; i < 12; i++) begin
      in_val = 1'b1;
      in_msg = mk(3'(i), 100 + i);
      #1;
      check_val("d_head", out_msg, sb[0]);
      check_val("d_count", count, 2);
      tick();
      void'(sb.pop_front());
      sb.push_back(mk(3'(i), 100 + i));
    end
    in_val = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check_val("d_tail", out_msg, sb[0]);
      tick();
      void'(sb.pop_front());
    end
    check_val("d_drained", count, 0);

    // Empty queue, local destination, only TERM granted
    out_rdy = 3'b100;
    in_val  = 1'b1;
    in_msg  = mk(3'd2, 30);
    #1;
`ifdef PLAB4_NET_INPUT_QUEUE_BYPASS_EN
    check_val("e_same_cycle_val", out_val, 3'b100);
    check_val("e_same_cycle_msg", out_msg, mk(3'd2, 30));
    tick();
    in_val = 1'b0;
    check_val("e_count", count, 0);
`else
    check_val("e_same_cycle_val", out_val, 3'b000);
    tick();
    in_val = 1'b0;
    #1;
    check_val("e_next_val", out_val, 3'b100);
    check_val("e_next_msg", out_msg, mk(3'd2, 30));
    check_val("e_count_1", count, 1);
    tick();
    check_val("e_count_0", count, 0);
`endif

    // Reset in the middle of a stream with three entries queued
    out_rdy = 3'b000;
    for (int i = 0; i < 3; i++) begin
      in_val = 1'b1;
      in_msg = mk(3'd3, 40 + i);
      tick();
    end
    in_val = 1'b0;
    check_val("f_pre_count", count, 3);
    reset = 1'b0;
    #1;
    check_val("f_rst_count", count, 0);
    check_val("f_rst_val", out_val, 3'b000);
    check_val("f_rst_rdy", in_rdy, 1);
    out_rdy = 3'b111;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_val("f_post_val", out_val, 3'b000);
      check_val("f_post_count", count, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
